// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the two-input AXIS packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_W = 32;

endpackage

// File: rtl/axis_arb_rr_sel.sv
// Combinational 2-way round-robin selector: on a tie the port that did not
// win last time is chosen.
module axis_arb_rr_sel
    import axis_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        gnt     = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_gnt;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/axis_pkt_arb2.sv
// Two-input packet-atomic round-robin AXI-Stream arbiter with a registered output.
// Define AXIS_ARB_STATS_EN to add the per-port packet counters pkt_cnt0/pkt_cnt1.
module axis_pkt_arb2
    import axis_arb_pkg::*;
#(
    parameter int TDATA_WIDTH  = 512,
    parameter int TUSER_WIDTH  = 1,
    parameter bit ENABLE_TLAST = 1'b1,
    parameter int TKEEP_WIDTH  = TDATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   s0_tvalid,
    output logic                   s0_tready,
    input  logic [TDATA_WIDTH-1:0] s0_tdata,
    input  logic [TKEEP_WIDTH-1:0] s0_tkeep,
    input  logic                   s0_tlast,
    input  logic [TUSER_WIDTH-1:0] s0_tuser,

    input  logic                   s1_tvalid,
    output logic                   s1_tready,
    input  logic [TDATA_WIDTH-1:0] s1_tdata,
    input  logic [TKEEP_WIDTH-1:0] s1_tkeep,
    input  logic                   s1_tlast,
    input  logic [TUSER_WIDTH-1:0] s1_tuser,

    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic [TKEEP_WIDTH-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic [TUSER_WIDTH-1:0] m_tuser,
    output logic                   m_tsrc
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [PKT_CNT_W-1:0]   pkt_cnt0,
    output logic [PKT_CNT_W-1:0]   pkt_cnt1
`endif
);

    arb_state_e state_q, state_d;
    logic gnt_q, gnt_d;
    logic last_gnt_q, last_gnt_d;
    logic m_tvalid_q, m_tvalid_d;
    logic m_tsrc_q, m_tsrc_d;

    logic [TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [TKEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
    logic                   m_tlast_q, m_tlast_d;
    logic [TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;

    logic sel_gnt;
    logic sel_vld;

    logic                   g_tvalid;
    logic [TDATA_WIDTH-1:0] g_tdata;
    logic [TKEEP_WIDTH-1:0] g_tkeep;
    logic                   g_tlast;
    logic [TUSER_WIDTH-1:0] g_tuser;

    logic lock;
    logic out_ready;
    logic accept;
    logic pkt_done;

    axis_arb_rr_sel u_rr_sel (
        .req      ({s1_tvalid, s0_tvalid}),
        .last_gnt (last_gnt_q),
        .gnt      (sel_gnt),
        .gnt_vld  (sel_vld)
    );

    // The output slot can take a beat when it is empty or being drained now.
    assign lock      = (state_q == LOCK);
    assign out_ready = ~m_tvalid_q | m_tready;

    assign g_tvalid = gnt_q ? s1_tvalid : s0_tvalid;
    assign g_tdata  = gnt_q ? s1_tdata  : s0_tdata;
    assign g_tkeep  = gnt_q ? s1_tkeep  : s0_tkeep;
    assign g_tlast  = gnt_q ? s1_tlast  : s0_tlast;
    assign g_tuser  = gnt_q ? s1_tuser  : s0_tuser;

    assign s0_tready = lock & ~gnt_q & out_ready;
    assign s1_tready = lock &  gnt_q & out_ready;

    assign accept   = lock & out_ready & g_tvalid;
    assign pkt_done = accept & (ENABLE_TLAST ? g_tlast : 1'b1);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gnt_d   = sel_gnt;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (pkt_done) begin
                    last_gnt_d = gnt_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tsrc_d   = m_tsrc_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        if (accept) begin
            m_tvalid_d = 1'b1;
            m_tsrc_d   = gnt_q;
            m_tdata_d  = g_tdata;
            m_tkeep_d  = g_tkeep;
            m_tlast_d  = g_tlast;
            m_tuser_d  = g_tuser;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            m_tvalid_q <= 1'b0;
            m_tsrc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            m_tvalid_q <= m_tvalid_d;
            m_tsrc_q   <= m_tsrc_d;
        end
    end

    // Payload needs no reset: it is only observed while m_tvalid is set.
    always_ff @(posedge clk) begin
        m_tdata_q <= m_tdata_d;
        m_tkeep_q <= m_tkeep_d;
        m_tlast_q <= m_tlast_d;
        m_tuser_q <= m_tuser_d;
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tsrc   = m_tsrc_q;
    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tlast  = ENABLE_TLAST ? m_tlast_q : 1'b0;
    assign m_tuser  = m_tuser_q;

`ifdef AXIS_ARB_STATS_EN
    logic [PKT_CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [PKT_CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

    always_comb begin
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        if (pkt_done) begin
            if (gnt_q)
                pkt_cnt1_d = pkt_cnt1_q + PKT_CNT_W'(1);
            else
                pkt_cnt0_d = pkt_cnt0_q + PKT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_axis_pkt_arb2.sv
// Self-checking bench for axis_pkt_arb2: directed scenarios plus randomized
// traffic, checked by a per-port packet scoreboard.
module tb_axis_pkt_arb2;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    logic          s0_tvalid, s0_tready, s0_tlast;
    logic [DW-1:0] s0_tdata;
    logic [KW-1:0] s0_tkeep;
    logic [UW-1:0] s0_tuser;
    logic          s1_tvalid, s1_tready, s1_tlast;
    logic [DW-1:0] s1_tdata;
    logic [KW-1:0] s1_tkeep;
    logic [UW-1:0] s1_tuser;
    logic          m_tvalid, m_tready, m_tlast, m_tsrc;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
`ifdef AXIS_ARB_STATS_EN
    logic [31:0]   pkt_cnt0, pkt_cnt1;
`endif

    beat_t drv[2];
    logic  drv_v[2];
    logic  rdy_random = 1'b0;
    logic  rdy_rand   = 1'b1;
    logic  rdy_man    = 1'b0;
    logic  abort      = 1'b0;
    logic  rand_gaps  = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    src_seq[$];
    int    out_pkts[2];
    logic  in_pkt;
    logic  cur_src;

    assign s0_tvalid = drv_v[0];
    assign s0_tdata  = drv[0].data;
    assign s0_tkeep  = drv[0].keep;
    assign s0_tuser  = drv[0].user;
    assign s0_tlast  = drv[0].last;
    assign s1_tvalid = drv_v[1];
    assign s1_tdata  = drv[1].data;
    assign s1_tkeep  = drv[1].keep;
    assign s1_tuser  = drv[1].user;
    assign s1_tlast  = drv[1].last;
    assign m_tready  = rdy_random ? rdy_rand : rdy_man;

    axis_pkt_arb2 #(
        .TDATA_WIDTH  (DW),
        .TUSER_WIDTH  (UW),
        .ENABLE_TLAST (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_tvalid (s0_tvalid),
        .s0_tready (s0_tready),
        .s0_tdata  (s0_tdata),
        .s0_tkeep  (s0_tkeep),
        .s0_tlast  (s0_tlast),
        .s0_tuser  (s0_tuser),
        .s1_tvalid (s1_tvalid),
        .s1_tready (s1_tready),
        .s1_tdata  (s1_tdata),
        .s1_tkeep  (s1_tkeep),
        .s1_tlast  (s1_tlast),
        .s1_tuser  (s1_tuser),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .m_tsrc    (m_tsrc)
`ifdef AXIS_ARB_STATS_EN
        ,
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic bit hs(input int port);
        return (port != 0) ? (s1_tvalid && s1_tready) : (s0_tvalid && s0_tready);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard: every accepted input beat is queued per port; every output
    // beat must be the oldest outstanding beat of its source, packets whole.
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        int    qs;
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            src_seq.delete();
            out_pkts[0] = 0;
            out_pkts[1] = 0;
            in_pkt      = 1'b0;
            cur_src     = 1'b0;
        end else begin
            if (m_tvalid && m_tready) begin
                got = {m_tdata, m_tkeep, m_tuser, m_tlast};
                if (in_pkt)
                    checkOutput("no_interleave", 64'(m_tsrc), 64'(cur_src));
                qs = m_tsrc ? exp_q1.size() : exp_q0.size();
                checkOutput("beat_expected", 64'(qs != 0), 64'd1);
                if (qs != 0) begin
                    exp = m_tsrc ? exp_q1.pop_front() : exp_q0.pop_front();
                    checkOutput("beat_payload", 64'(got), 64'(exp));
                end
                in_pkt  = !m_tlast;
                cur_src = m_tsrc;
                if (m_tlast) begin
                    out_pkts[m_tsrc]++;
                    src_seq.push_back(int'(m_tsrc));
                end
            end
            if (s0_tready || s1_tready)
                checkOutput("tready_exclusive", 64'(s0_tready && s1_tready), 64'd0);
            if (hs(0)) exp_q0.push_back(drv[0]);
            if (hs(1)) exp_q1.push_back(drv[1]);
        end
    end

    // Sends one packet on a port; gap_at inserts gap_len idle cycles before that beat.
    task automatic applyStimulus(input int port, input int len, input logic [DW-1:0] base,
                                 input bit rnd, input int gap_at, input int gap_len);
        int idle;
        int cnt;
        for (int i = 0; i < len; i++) begin
            idle = 0;
            if (i == gap_at) idle = gap_len;
            else if (rand_gaps && $urandom_range(0, 3) == 0) idle = $urandom_range(1, 2);
            if (idle > 0) begin
                drv_v[port] = 1'b0;
                repeat (idle) begin @(posedge clk); #1; end
            end
            drv[port].data = rnd ? DW'($urandom) : base + DW'(i);
            drv[port].keep = KW'($urandom);
            drv[port].user = UW'($urandom);
            drv[port].last = (i == len - 1);
            drv_v[port]    = 1'b1;
            cnt = 0;
            forever begin
                @(negedge clk);
                if (abort) begin
                    drv_v[port] = 1'b0;
                    return;
                end
                if (hs(port)) break;
                cnt++;
                if (cnt > 2000) begin
                    checkOutput("handshake_timeout", 64'(cnt), 64'd0);
                    drv_v[port] = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        drv_v[port] = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic checkAlternation(input string tag, input int n);
        checkOutput({tag, "_pkt_count"}, 64'(src_seq.size()), 64'(n));
        for (int i = 0; i < src_seq.size(); i++)
            checkOutput({tag, "_order"}, 64'(src_seq[i]), 64'(i % 2));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_q0_empty"}, 64'(exp_q0.size()), 64'd0);
        checkOutput({tag, "_q1_empty"}, 64'(exp_q1.size()), 64'd0);
    endtask

    initial begin
        #500000;
        tests_failed++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int cnt;
        rst_n    = 1'b0;
        drv_v[0] = 1'b0;
        drv_v[1] = 1'b0;
        drv[0]   = '0;
        drv[1]   = '0;
        rdy_man  = 1'b1;

        // Reset state, with both inputs requesting and the sink ready
        @(posedge clk); #1;
        drv_v[0] = 1'b1;
        drv_v[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_s0_tready", 64'(s0_tready), 64'd0);
        checkOutput("rst_s1_tready", 64'(s1_tready), 64'd0);
        checkOutput("rst_m_tsrc", 64'(m_tsrc), 64'd0);
        @(posedge clk); #1;
        drv_v[0] = 1'b0;
        drv_v[1] = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;

        // Single 3-beat packet on s0, output appears 2 cycles after tvalid
        fork
            applyStimulus(0, 3, 32'hA0, 1'b0, -1, 0);
            begin
                lat = 0;
                @(negedge clk);
                while (!m_tvalid && lat < 20) begin
                    lat++;
                    @(negedge clk);
                end
                checkOutput("t1_latency", 64'(lat), 64'd2);
                checkOutput("t1_first_data", 64'(m_tdata), 64'hA0);
                checkOutput("t1_src", 64'(m_tsrc), 64'd0);
            end
        join
        drain(5);
        checkOutput("t1_pkts0", 64'(out_pkts[0]), 64'd1);
        checkEmpty("t1");

        // Both ports ready at once after reset: s0 wins the first tie
        applyReset();
        fork
            applyStimulus(0, 2, 32'hB0, 1'b0, -1, 0);
            applyStimulus(1, 2, 32'hC0, 1'b0, -1, 0);
        join
        drain(5);
        checkAlternation("t2", 2);
        checkEmpty("t2");

        // Continuous traffic, 10 packets per port: grants alternate
        applyReset();
        fork
            repeat (10) applyStimulus(0, $urandom_range(1, 4), 32'h0, 1'b1, -1, 0);
            repeat (10) applyStimulus(1, $urandom_range(1, 4), 32'h0, 1'b1, -1, 0);
        join
        drain(5);
        checkAlternation("t3", 20);
        checkOutput("t3_pkts0", 64'(out_pkts[0]), 64'd10);
        checkOutput("t3_pkts1", 64'(out_pkts[1]), 64'd10);
        checkEmpty("t3");
`ifdef AXIS_ARB_STATS_EN
        checkOutput("t3_pkt_cnt0", 64'(pkt_cnt0), 64'd10);
        checkOutput("t3_pkt_cnt1", 64'(pkt_cnt1), 64'd10);
`endif

        // Output backpressure held for 4 cycles on the second beat
        applyReset();
        fork
            applyStimulus(0, 3, 32'hD0, 1'b0, -1, 0);
            begin
                cnt = 0;
                do begin
                    @(negedge clk);
                    cnt++;
                end while (!(m_tvalid && m_tdata == 32'hD0) && cnt < 50);
                checkOutput("t4_first_seen", 64'(m_tdata), 64'hD0);
                @(posedge clk); #1;
                rdy_man = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("t4_data_stable", 64'(m_tdata), 64'hD1);
                    checkOutput("t4_valid_held", 64'(m_tvalid), 64'd1);
                    checkOutput("t4_s0_blocked", 64'(s0_tready), 64'd0);
                end
                @(posedge clk); #1;
                rdy_man = 1'b1;
            end
        join
        drain(5);
        checkOutput("t4_pkts0", 64'(out_pkts[0]), 64'd1);
        checkEmpty("t4");

        // s1 pauses mid-packet while s0 waits; s0 stays blocked until s1's tlast
        applyReset();
        fork
            applyStimulus(1, 4, 32'hE0, 1'b0, 2, 3);
            begin
                cnt = 0;
                do begin
                    @(negedge clk);
                    cnt++;
                end while (!hs(1) && cnt < 50);
                @(posedge clk); #1;
                applyStimulus(0, 2, 32'hF0, 1'b0, -1, 0);
            end
            begin
                cnt = 0;
                forever begin
                    @(negedge clk);
                    if ((hs(1) && s1_tlast) || cnt > 50) break;
                    checkOutput("t5_s0_blocked", 64'(s0_tready), 64'd0);
                    cnt++;
                end
            end
        join
        drain(5);
        checkOutput("t5_pkt_count", 64'(src_seq.size()), 64'd2);
        if (src_seq.size() == 2) begin
            checkOutput("t5_first_src", 64'(src_seq[0]), 64'd1);
            checkOutput("t5_second_src", 64'(src_seq[1]), 64'd0);
        end
        checkEmpty("t5");

        // Reset in the middle of a 4-beat packet, then a clean packet
        applyReset();
        fork
            applyStimulus(0, 4, 32'h10, 1'b0, -1, 0);
            begin
                cnt = 0;
                lat = 0;
                while (cnt < 2 && lat < 50) begin
                    @(negedge clk);
                    if (hs(0)) cnt++;
                    lat++;
                end
                @(posedge clk); #1;
                rst_n = 1'b0;
                abort = 1'b1;
                @(posedge clk);
                @(negedge clk);
                checkOutput("t6_m_tvalid", 64'(m_tvalid), 64'd0);
                checkOutput("t6_s0_tready", 64'(s0_tready), 64'd0);
                checkOutput("t6_s1_tready", 64'(s1_tready), 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                abort = 1'b0;
            end
        join
        applyStimulus(0, 3, 32'h20, 1'b0, -1, 0);
        drain(5);
        checkOutput("t6_pkts0", 64'(out_pkts[0]), 64'd1);
        checkOutput("t6_pkts1", 64'(out_pkts[1]), 64'd0);
        checkEmpty("t6");

        // Randomized traffic with source gaps and random sink backpressure
        applyReset();
        rdy_random = 1'b1;
        rand_gaps  = 1'b1;
        fork
            repeat (25) applyStimulus(0, $urandom_range(1, 6), 32'h0, 1'b1, -1, 0);
            repeat (25) applyStimulus(1, $urandom_range(1, 6), 32'h0, 1'b1, -1, 0);
        join
        rdy_man    = 1'b1;
        rdy_random = 1'b0;
        rand_gaps  = 1'b0;
        drain(10);
        checkOutput("t7_pkts0", 64'(out_pkts[0]), 64'd25);
        checkOutput("t7_pkts1", 64'(out_pkts[1]), 64'd25);
        checkEmpty("t7");
`ifdef AXIS_ARB_STATS_EN
        checkOutput("t7_pkt_cnt0", 64'(pkt_cnt0), 64'd25);
        checkOutput("t7_pkt_cnt1", 64'(pkt_cnt1), 64'd25);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
